// File: rtl/activation_pipe.sv
// Two-stage streaming fixed-point activation unit.
// Applies LReLU / piecewise sigmoid / piecewise tanh to LANES samples.
module activation_pipe #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic [1:0]             in_mode,
  input  logic [WIDTH-1:0]       in_alpha,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic [LANES-1:0]       out_sat
);

  localparam int W2 = WIDTH + 2;
  localparam int WP = 2 * WIDTH;

  localparam logic signed [W2-1:0] C_ONE  = W2'(1) << FRAC;
  localparam logic signed [W2-1:0] C_TWO  = C_ONE <<< 1;
  localparam logic signed [W2-1:0] C_1P5  = C_ONE + (C_ONE >>> 1);
  localparam logic signed [W2-1:0] C_0P125 = C_ONE >>> 3;
  localparam logic signed [W2-1:0] C_0P875 = C_ONE - C_0P125;
  localparam logic signed [W2-1:0] C_0P25 = C_ONE >>> 2;
  localparam logic signed [W2-1:0] C_0P75 = C_ONE - C_0P25;
  localparam logic signed [W2-1:0] C_1P75 = C_ONE + C_0P75;

  localparam logic signed [WIDTH-1:0] Y_MAX =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] Y_MIN =
    {1'b1, {(WIDTH-1){1'b0}}};

  // Leaky ReLU on the full-width product so that no intermediate wraps.
  function automatic logic signed [WP-1:0] f_lrelu(
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] a
  );
    logic signed [WP-1:0] p;
    logic signed [WP-1:0] r;
    p = WP'(a) * WP'(x);
    if (x > 0) r = WP'(x);
    else       r = p >>> FRAC;
    return r;
  endfunction

  // Three-segment sigmoid: clamps beyond +/-2, linear x/4+1/2 inside.
  function automatic logic signed [W2-1:0] f_sig3(
    input logic signed [W2-1:0] x
  );
    logic signed [W2-1:0] r;
    if (x > C_TWO)       r = C_ONE;
    else if (x < -C_TWO) r = '0;
    else                 r = ((x >>> 1) + C_ONE) >>> 1;
    return r;
  endfunction

  // Five-segment sigmoid with breakpoints at 0.75 and 1.75.
  function automatic logic signed [W2-1:0] f_sig5(
    input logic signed [W2-1:0] x
  );
    logic signed [W2-1:0] x2;
    logic signed [W2-1:0] r;
    x2 = x <<< 1;
    if (x >= C_1P75)
      r = C_ONE;
    else if (x <= -C_1P75)
      r = '0;
    else if (x < -C_0P75)
      r = (((x2 + C_1P5) >>> 2) + C_0P125) >>> 1;
    else if (x > C_0P75)
      r = (((x2 - C_1P5) >>> 2) + C_0P875) >>> 1;
    else
      r = ((x >>> 1) + C_ONE) >>> 1;
    return r;
  endfunction

  // Five-segment tanh with breakpoints at 0.25 and 0.75.
  function automatic logic signed [W2-1:0] f_tanh5(
    input logic signed [W2-1:0] x
  );
    logic signed [W2-1:0] x2;
    logic signed [W2-1:0] r;
    x2 = x <<< 1;
    if (x >= C_0P75)
      r = C_ONE;
    else if (x <= -C_0P75)
      r = -C_ONE;
    else if (x < -C_0P25)
      r = (x2 + C_0P25) >>> 2;
    else if (x > C_0P25)
      r = (x2 - C_0P25) >>> 2;
    else
      r = x;
    return r;
  endfunction

  // Clamp to the sample range; top bit of the result is the clamp flag.
  function automatic logic [WIDTH:0] f_clamp(
    input logic signed [WP-1:0] v
  );
    logic [WIDTH:0] r;
    if (v > WP'(Y_MAX))
      r = {1'b1, Y_MAX};
    else if (v < WP'(Y_MIN))
      r = {1'b1, Y_MIN};
    else
      r = {1'b0, v[WIDTH-1:0]};
    return r;
  endfunction

  // One lane: select the activation, then clamp.
  function automatic logic [WIDTH:0] f_act(
    input logic [1:0]              m,
    input logic signed [WIDTH-1:0] x,
    input logic signed [WIDTH-1:0] a
  );
    logic signed [W2-1:0] xe;
    logic signed [WP-1:0] v;
    xe = W2'(x);
    v  = '0;
    unique case (m)
      2'd0: v = f_lrelu(x, a);
      2'd1: v = WP'(f_sig3(xe));
      2'd2: v = WP'(f_sig5(xe));
      2'd3: v = WP'(f_tanh5(xe));
    endcase
    return f_clamp(v);
  endfunction

  logic                   r_s1_valid;
  logic [LANES*WIDTH-1:0] r_s1_data;
  logic [1:0]             r_s1_mode;
  logic [WIDTH-1:0]       r_s1_alpha;

  logic                   r_out_valid;
  logic [LANES*WIDTH-1:0] r_out_data;
  logic [LANES-1:0]       r_out_sat;

  logic                   w_s1_load;
  logic                   w_s2_load;
  logic [LANES*WIDTH-1:0] w_act_data;
  logic [LANES-1:0]       w_act_sat;

  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_load = !r_s1_valid || w_s2_load;
  assign in_ready  = w_s1_load;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sat   = r_out_sat;

  // Per-lane activation of the beat held in stage 1.
  always_comb begin
    w_act_data = '0;
    w_act_sat  = '0;
    for (int i = 0; i < LANES; i++) begin
      {w_act_sat[i], w_act_data[i*WIDTH +: WIDTH]} =
        f_act(r_s1_mode, r_s1_data[i*WIDTH +: WIDTH],
              r_s1_alpha);
    end
  end

  // Stage 1: capture the beat with its own mode and alpha.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
      r_s1_mode  <= '0;
      r_s1_alpha <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_data  <= in_data;
        r_s1_mode  <= in_mode;
        r_s1_alpha <= in_alpha;
      end
    end
  end

  // Stage 2: register the activated beat when downstream has room.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sat   <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= w_act_data;
        r_out_sat  <= w_act_sat;
      end
    end
  end

endmodule

// File: tb/tb_activation_pipe.sv
// Directed bench for activation_pipe.
// Table of hand-computed vectors reused by single-beat and stream tests.
module tb_activation_pipe;

  localparam int NV = 14;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic [15:0] in_alpha = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_data;
  logic [3:0]  out_sat;

  int n_tests = 0;
  int n_fail  = 0;

  logic [1:0]  vmode  [NV];
  logic [15:0] valpha [NV];
  logic [63:0] vin    [NV];
  logic [63:0] vexp   [NV];
  logic [3:0]  vsat   [NV];

  activation_pipe #(.WIDTH(16), .FRAC(8), .LANES(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .in_alpha  (in_alpha),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pk(int a, int b, int c, int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  task automatic set_vec(input int i, input logic [1:0] m,
                         input logic [15:0] a, input logic [63:0] x,
                         input logic [63:0] y, input logic [3:0] s);
    vmode[i] = m; valpha[i] = a; vin[i] = x; vexp[i] = y; vsat[i] = s;
  endtask

  task automatic init_vectors;
    set_vec(0, 2'd0, 16'h0019, pk(-256, 300, 0, -1),
            pk(-25, 300, 0, -1), 4'b0000);
    set_vec(1, 2'd1, 16'h8000, pk(0, 600, -600, 512),
            pk(128, 256, 0, 256), 4'b0000);
    set_vec(2, 2'd1, 16'h0019, pk(-512, 513, -1, 1),
            pk(0, 256, 127, 128), 4'b0000);
    // -300 lies in the negative middle segment:
    // ((((-600)+384)>>>2)+32)>>>1 = (-54+32)>>>1 = -11
    set_vec(3, 2'd2, 16'h0019, pk(300, -300, 448, -448),
            pk(139, -11, 256, 0), 4'b0000);
    set_vec(4, 2'd2, 16'h0019, pk(192, -192, 447, -447),
            pk(176, 80, 175, -48), 4'b0000);
    set_vec(5, 2'd3, 16'h0019, pk(100, -1000, 32, -100),
            pk(34, -256, 32, -34), 4'b0000);
    set_vec(6, 2'd3, 16'h0019, pk(192, -192, 64, -64),
            pk(256, -256, 64, -64), 4'b0000);
    set_vec(7, 2'd3, 16'h0019, pk(191, -191, 65, -65),
            pk(79, -80, 16, -17), 4'b0000);
    set_vec(8, 2'd0, 16'h0019, pk(-32768, 32767, -32768, 32767),
            pk(-3200, 32767, -3200, 32767), 4'b0000);
    set_vec(9, 2'd1, 16'h0019, pk(-32768, 32767, -32768, 32767),
            pk(0, 256, 0, 256), 4'b0000);
    set_vec(10, 2'd2, 16'h0019, pk(-32768, 32767, -32768, 32767),
            pk(0, 256, 0, 256), 4'b0000);
    set_vec(11, 2'd3, 16'h0019, pk(-32768, 32767, -32768, 32767),
            pk(-256, 256, -256, 256), 4'b0000);
    set_vec(12, 2'd0, 16'h7FFF, pk(-32768, 5, -256, 100),
            pk(-32768, 5, -32767, 100), 4'b0001);
    set_vec(13, 2'd0, 16'h8000, pk(0, -32768, -1, 7),
            pk(0, 32767, 128, 7), 4'b0010);
  endtask

  task automatic run_beat(input int v, output logic [63:0] od,
                          output logic [3:0] os, output int lat,
                          output logic rdy);
    @(negedge clk);
    in_mode   = vmode[v];
    in_alpha  = valpha[v];
    in_data   = vin[v];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1 rdy = in_ready;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    od = out_data;
    os = out_sat;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset out_valid: got %b exp 0", out_valid);
    end
    n_tests++;
    if (out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset out_data: got %h exp 0", out_data);
    end
    n_tests++;
    if (out_sat !== 4'h0) begin
      n_fail++;
      $display("FAIL reset out_sat: got %b exp 0", out_sat);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset in_ready: got %b exp 1", in_ready);
    end
  endtask

  task automatic test_lrelu;
    logic [63:0] od;
    logic [3:0]  os;
    int          lat;
    logic        rdy;
    run_beat(0, od, os, lat, rdy);
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL lrelu in_ready: got %b exp 1", rdy);
    end
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL lrelu latency: got %0d exp 2", lat);
    end
    n_tests++;
    if (od !== vexp[0]) begin
      n_fail++;
      $display("FAIL lrelu data: got %h exp %h", od, vexp[0]);
    end
    n_tests++;
    if (os !== vsat[0]) begin
      n_fail++;
      $display("FAIL lrelu sat: got %b exp %b", os, vsat[0]);
    end
  endtask

  task automatic test_sigmoid;
    logic [63:0] od;
    logic [3:0]  os;
    int          lat;
    logic        rdy;
    for (int v = 1; v <= 4; v++) begin
      run_beat(v, od, os, lat, rdy);
      n_tests++;
      if (od !== vexp[v]) begin
        n_fail++;
        $display("FAIL sigmoid v%0d data: got %h exp %h", v, od, vexp[v]);
      end
      n_tests++;
      if (os !== vsat[v]) begin
        n_fail++;
        $display("FAIL sigmoid v%0d sat: got %b exp %b", v, os, vsat[v]);
      end
    end
  endtask

  task automatic test_tanh;
    logic [63:0] od;
    logic [3:0]  os;
    int          lat;
    logic        rdy;
    for (int v = 5; v <= 7; v++) begin
      run_beat(v, od, os, lat, rdy);
      n_tests++;
      if (od !== vexp[v]) begin
        n_fail++;
        $display("FAIL tanh v%0d data: got %h exp %h", v, od, vexp[v]);
      end
      n_tests++;
      if (os !== vsat[v]) begin
        n_fail++;
        $display("FAIL tanh v%0d sat: got %b exp %b", v, os, vsat[v]);
      end
    end
  endtask

  task automatic test_extremes;
    logic [63:0] od;
    logic [3:0]  os;
    int          lat;
    logic        rdy;
    for (int v = 8; v <= 11; v++) begin
      run_beat(v, od, os, lat, rdy);
      n_tests++;
      if (od !== vexp[v]) begin
        n_fail++;
        $display("FAIL extreme v%0d data: got %h exp %h", v, od, vexp[v]);
      end
      n_tests++;
      if (os !== vsat[v]) begin
        n_fail++;
        $display("FAIL extreme v%0d sat: got %b exp %b", v, os, vsat[v]);
      end
    end
  endtask

  task automatic test_saturation;
    logic [63:0] od;
    logic [3:0]  os;
    int          lat;
    logic        rdy;
    for (int v = 12; v <= 13; v++) begin
      run_beat(v, od, os, lat, rdy);
      n_tests++;
      if (od !== vexp[v]) begin
        n_fail++;
        $display("FAIL satur v%0d data: got %h exp %h", v, od, vexp[v]);
      end
      n_tests++;
      if (os !== vsat[v]) begin
        n_fail++;
        $display("FAIL satur v%0d sat: got %b exp %b", v, os, vsat[v]);
      end
    end
  endtask

  task automatic test_back_to_back;
    int   sent, rcvd, occ, cyc, idx;
    logic acc, lv, exp_rdy;
    sent = 0; rcvd = 0; occ = 0; cyc = 0;
    while (rcvd < 20 && cyc < 600) begin
      @(negedge clk);
      idx      = sent % NV;
      in_mode  = vmode[idx];
      in_alpha = valpha[idx];
      in_data  = vin[idx];
      if (sent >= 20)   in_valid = 1'b0;
      else if (cyc < 6) in_valid = 1'b1;
      else              in_valid = 1'($urandom_range(0, 3) != 0);
      if (cyc < 6) out_ready = 1'b0;
      else         out_ready = 1'($urandom_range(0, 2) != 0);
      #1;
      exp_rdy = !(occ == 2 && !out_ready);
      n_tests++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL b2b in_ready cyc%0d: got %b exp %b",
                 cyc, in_ready, exp_rdy);
      end
      if (occ == 0) begin
        n_tests++;
        if (out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b empty out_valid cyc%0d: got %b exp 0",
                   cyc, out_valid);
        end
      end
      acc = in_valid & in_ready;
      lv  = out_valid & out_ready;
      if (lv) begin
        idx = rcvd % NV;
        n_tests++;
        if (out_data !== vexp[idx] || out_sat !== vsat[idx]) begin
          n_fail++;
          $display("FAIL b2b beat%0d: got %h/%b exp %h/%b",
                   rcvd, out_data, out_sat, vexp[idx], vsat[idx]);
        end
        rcvd++;
      end
      @(posedge clk);
      if (acc) begin sent++; occ++; end
      if (lv) occ--;
      n_tests++;
      if (occ > 2 || occ < 0) begin
        n_fail++;
        $display("FAIL b2b occupancy cyc%0d: got %0d exp 0..2", cyc, occ);
      end
      cyc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    n_tests++;
    if (rcvd != 20) begin
      n_fail++;
      $display("FAIL b2b count: got %0d exp 20", rcvd);
    end
  endtask

  task automatic test_reset_midstream;
    logic [63:0] od;
    logic [3:0]  os;
    int          lat;
    logic        rdy;
    @(negedge clk);
    out_ready = 1'b0;
    in_mode = vmode[0]; in_alpha = valpha[0]; in_data = vin[0];
    in_valid = 1'b1;
    @(negedge clk);
    in_mode = vmode[1]; in_alpha = valpha[1]; in_data = vin[1];
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst full: got v=%b r=%b exp v=1 r=0",
               out_valid, in_ready);
    end
    #1 rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst async out_valid: got %b exp 0", out_valid);
    end
    n_tests++;
    if (out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL midrst out_data: got %h exp 0", out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_beat(5, od, os, lat, rdy);
    n_tests++;
    if (lat != 2) begin
      n_fail++;
      $display("FAIL midrst latency: got %0d exp 2", lat);
    end
    n_tests++;
    if (od !== vexp[5]) begin
      n_fail++;
      $display("FAIL midrst data: got %h exp %h", od, vexp[5]);
    end
  endtask

  initial begin
    init_vectors();
    test_reset();
    test_lrelu();
    test_sigmoid();
    test_tanh();
    test_extremes();
    test_saturation();
    test_back_to_back();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog");
  end

endmodule
